// File: rtl/pipe_cpu_pkg.sv
// Shared constants for the pipelined CPU front end.
package pipe_cpu_pkg;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear, used for the pc-queue and the instruction buffer.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency imem and drives the IF_ID register.
module if_fetch_unit
  import pipe_cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               stall_i,
  output logic               if_id_valid_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic [INSTR_W-1:0] if_id_instr_o
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   outst_q, outst_d, drop_q, drop_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic [ADDR_W-1:0]  pcq_head;
  logic [CNT_W-1:0]   pcq_cnt, buf_cnt;
  logic [ENT_W-1:0]   buf_head, resp;
  logic               rvalid_ok, retire_keep, deliver, fire, loadable;
  logic               buf_push, buf_pop;

  always_comb begin
    rvalid_ok   = imem_rvalid_i && (outst_q != '0);
    retire_keep = rvalid_ok && (drop_q == '0);
    deliver     = retire_keep && !redirect_i;
    imem_req_o  = rst_i && !redirect_i &&
                  ((SUM_W'(outst_q) + SUM_W'(buf_cnt)) < SUM_W'(DEPTH));
    fire        = imem_req_o && imem_gnt_i;
    resp        = {pcq_head + ADDR_W'(4), imem_rdata_i};
    loadable    = !stall_i || !valid_q;

    buf_push = 1'b0;
    buf_pop  = 1'b0;
    valid_d  = valid_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    pc_d     = fire ? pc_q + ADDR_W'(4) : pc_q;
    outst_d  = outst_q + CNT_W'(fire) - CNT_W'(rvalid_ok);
    drop_d   = (rvalid_ok && (drop_q != '0)) ? drop_q - CNT_W'(1) : drop_q;

    // Redirect wins over stall; everything still in flight becomes stale.
    if (redirect_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = redirect_pc_i;
      drop_d  = outst_q - CNT_W'(rvalid_ok);
    end else if (loadable) begin
      if (buf_cnt != '0) begin
        {pc4_d, instr_d} = buf_head;
        valid_d  = 1'b1;
        buf_pop  = 1'b1;
        buf_push = deliver;
      end else if (deliver) begin
        {pc4_d, instr_d} = resp;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      buf_push = deliver;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fire),
    .data_i  (pc_q),
    .pop_i   (retire_keep),
    .clear_i (redirect_i),
    .head_o  (pcq_head),
    .count_o (pcq_cnt)
  );

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_instr_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (buf_push),
    .data_i  (resp),
    .pop_i   (buf_pop),
    .clear_i (redirect_i),
    .head_o  (buf_head),
    .count_o (buf_cnt)
  );

  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = valid_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_instr_o = instr_q;

  a_credit : assert property (@(posedge clk_i) disable iff (!rst_i)
    (SUM_W'(outst_q) + SUM_W'(buf_cnt)) <= SUM_W'(DEPTH));
  a_drop : assert property (@(posedge clk_i) disable iff (!rst_i) drop_q <= outst_q);
  a_pcq : assert property (@(posedge clk_i) disable iff (!rst_i) pcq_cnt == (outst_q - drop_q));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based model of the fetch rules.
module tb_if_fetch_unit;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, stall = 1'b0;
  logic [31:0] addr, rdata = '0, redirect_pc = '0;
  logic        valid;
  logic [31:0] pc4, instr;

  logic        w_rst = 1'b0;
  logic        w_req, w_gnt = 1'b0, w_rvalid = 1'b0;
  logic [31:0] w_addr, w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_pc4, w_instr;

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .stall_i(stall), .if_id_valid_o(valid), .if_id_pc4_o(pc4), .if_id_instr_o(instr)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk_i(clk), .rst_i(w_rst), .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .stall_i(1'b0), .if_id_valid_o(w_valid), .if_id_pc4_o(w_pc4), .if_id_instr_o(w_instr)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: in-flight fetches (with stale flag), buffered instructions, IF_ID contents.
  typedef struct packed { logic [31:0] pc; logic drop; } inf_t;
  typedef struct packed { logic [31:0] pc4; logic [31:0] instr; } ent_t;
  typedef struct packed { int unsigned due; logic [31:0] addr; } mem_t;

  inf_t        m_inf[$];
  ent_t        m_buf[$];
  mem_t        mem_q[$];
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int unsigned cyc = 0;

  task automatic model_reset();
    m_inf.delete(); m_buf.delete(); mem_q.delete();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic red, input logic [31:0] rpc, input logic st,
                            input logic fire, input logic rv);
    inf_t f;
    ent_t e;
    logic deliver;
    f = '0;
    deliver = 1'b0;
    if (rv && m_inf.size() > 0) begin
      f = m_inf.pop_front();
      deliver = !f.drop && !red;
    end
    if (red) begin
      for (int i = 0; i < m_inf.size(); i++) m_inf[i].drop = 1'b1;
      m_buf.delete();
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc    = rpc;
    end else begin
      e.pc4   = f.pc + 32'd4;
      e.instr = fdata(f.pc);
      if (!st || !m_valid) begin
        if (m_buf.size() > 0) begin
          e = m_buf.pop_front();
          m_pc4 = e.pc4; m_instr = e.instr; m_valid = 1'b1;
          if (deliver) begin
            e.pc4 = f.pc + 32'd4; e.instr = fdata(f.pc);
            m_buf.push_back(e);
          end
        end else if (deliver) begin
          m_pc4 = e.pc4; m_instr = e.instr; m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else if (deliver) begin
        m_buf.push_back(e);
      end
      if (fire) begin
        m_inf.push_back('{pc: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic step(input logic red, input logic [31:0] rpc, input logic st,
                      input logic g, input int unsigned lat);
    logic exp_req;
    logic rv;
    redirect = red; redirect_pc = rpc; stall = st; gnt = g;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rvalid = rv;
    rdata = rv ? fdata(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_req = !red && ((m_inf.size() + m_buf.size()) < DEPTH);
    check_eq("req", {31'b0, req}, {31'b0, exp_req});
    if (exp_req) check_eq("addr", addr, m_pc);
    if (rv) void'(mem_q.pop_front());
    if (req && g) mem_q.push_back('{due: cyc + lat, addr: addr});
    model_step(red, rpc, st, exp_req && g, rv);
    @(posedge clk);
    cyc++;
    #1;
    check_eq("valid", {31'b0, valid}, {31'b0, m_valid});
    check_eq("pc4", pc4, m_pc4);
    check_eq("instr", instr, m_instr);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; rvalid = 1'b0; redirect = 1'b0; gnt = 1'b0; stall = 1'b0;
    #1;
    check_eq("rst_req", {31'b0, req}, 32'h0);
    check_eq("rst_valid", {31'b0, valid}, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    #2;
    check_eq("por_req", {31'b0, req}, 32'h0);
    check_eq("por_pc4", pc4, 32'h0);

    // PC wrap and stray response on the second instance.
    @(posedge clk); #1;
    w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hBAD0_BAD0;
    #1;
    check_eq("w_req", {31'b0, w_req}, 32'h1);
    check_eq("w_addr0", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_eq("w_stray_valid", {31'b0, w_valid}, 32'h0);
    check_eq("w_stray_addr", w_addr, 32'hFFFF_FFFC);
    w_rvalid = 1'b0; w_gnt = 1'b1;
    @(posedge clk); #1;
    check_eq("w_addr1", w_addr, 32'h0);
    w_rvalid = 1'b1; w_rdata = 32'h1111_0001;
    @(posedge clk); #1;
    check_eq("w_valid1", {31'b0, w_valid}, 32'h1);
    check_eq("w_pc4_1", w_pc4, 32'h0);
    check_eq("w_instr1", w_instr, 32'h1111_0001);
    check_eq("w_addr2", w_addr, 32'h4);
    w_rdata = 32'h2222_0002;
    @(posedge clk); #1;
    check_eq("w_pc4_2", w_pc4, 32'h4);
    check_eq("w_instr2", w_instr, 32'h2222_0002);
    w_rvalid = 1'b0; w_gnt = 1'b0;

    do_reset();
    // Streaming with zero-wait memory.
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    // Stall while responses keep arriving.
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    // Redirect with long-latency fetches outstanding.
    do_reset();
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 3);
    step(1'b1, 32'h100, 1'b0, 1'b1, 3);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 3);
    // Redirect together with stall and a returning response.
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    // Mid-run reset, then random traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(1, 4));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
